// File: rtl/ftm_pkg.sv
// rtl/ftm_pkg.sv - shared types and constants for the FTM checkpoint responder
package ftm_pkg;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    FROZEN  = 2'd1,
    RECOVER = 2'd2
  } ftm_ckpt_state_e;

  localparam int unsigned MISMCNT_W = 16;

  localparam logic [5:0] IDX_PC      = 6'd32;
  localparam logic [5:0] IDX_STATUS  = 6'd33;
  localparam logic [5:0] IDX_MISMCNT = 6'd34;

  // The counter sticks at all-ones so a storm of mismatches never wraps to a small value.
  function automatic logic [MISMCNT_W-1:0] sat_inc(input logic [MISMCNT_W-1:0] v);
    return (v == '1) ? v : v + MISMCNT_W'(1);
  endfunction

endpackage

// File: rtl/ftm_ckpt_responder_if.sv
// rtl/ftm_ckpt_responder_if.sv - LSU-style req/gnt/rvalid data bus
interface ftm_ckpt_responder_if;

  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_err;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata, data_err
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata, data_err
  );

endinterface

// File: rtl/ftm_lane_compare.sv
// rtl/ftm_lane_compare.sv - combinational comparison of the two regfile write lanes
module ftm_lane_compare (
  input  logic        we_a,
  input  logic [4:0]  addr_a,
  input  logic [31:0] data_a,
  input  logic        we_b,
  input  logic [4:0]  addr_b,
  input  logic [31:0] data_b,
  output logic        agree,
  output logic        mismatch
);

  logic same_target;

  assign same_target = (addr_a == addr_b) && (data_a == data_b);

  // Matching writes to x0 are neither a commit nor a disagreement.
  assign agree    = we_a && we_b && same_target && (addr_a != 5'd0);
  assign mismatch = (we_a != we_b) || (we_a && we_b && !same_target);

endmodule

// File: rtl/ftm_ckpt_responder.sv
// rtl/ftm_ckpt_responder.sv - lockstep checkpoint store and recovery data-bus responder
module ftm_ckpt_responder
  import ftm_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h0000_F000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_a_i,
  input  logic                       we_b_i,
  input  logic [4:0]                 addr_a_i,
  input  logic [4:0]                 addr_b_i,
  input  logic [31:0]                data_a_i,
  input  logic [31:0]                data_b_i,
  input  logic [31:0]                pc_i,
  input  logic                       valid_instr_exec_i,
  input  logic                       recovering_i,
  ftm_ckpt_responder_if.slave        bus,
  output logic                       mismatch_o,
  output logic                       ckpt_valid_o
);

  ftm_ckpt_state_e       state_q, state_d;
  logic                  lane_agree, lane_mismatch, commit;
  logic [31:0]           shadow_q [1:31];
  logic [31:0]           pc_q;
  logic [MISMCNT_W-1:0]  mismcnt_q;
  logic                  mismatch_q, ckpt_valid_q;
  logic                  rvalid_q, err_q;
  logic [31:0]           rdata_q;
  logic                  win_hit;
  logic [5:0]            idx;
  logic [31:0]           rd_data;
  logic                  rd_err;
  logic                  unused_bus;

  ftm_lane_compare u_cmp (
    .we_a     (we_a_i),
    .addr_a   (addr_a_i),
    .data_a   (data_a_i),
    .we_b     (we_b_i),
    .addr_b   (addr_b_i),
    .data_b   (data_b_i),
    .agree    (lane_agree),
    .mismatch (lane_mismatch)
  );

  assign commit = lane_agree && (state_q == CAPTURE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CAPTURE;
    end else begin
      state_q <= state_d;
    end
  end

  // A mismatch freezes the checkpoint even if recovery starts in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE: begin
        if (lane_mismatch) begin
          state_d = FROZEN;
        end else if (recovering_i) begin
          state_d = RECOVER;
        end
      end
      FROZEN: begin
        if (recovering_i) begin
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        if (!recovering_i) begin
          state_d = CAPTURE;
        end
      end
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 1; i < 32; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (commit) begin
      shadow_q[addr_a_i] <= data_a_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q         <= '0;
      mismcnt_q    <= '0;
      mismatch_q   <= 1'b0;
      ckpt_valid_q <= 1'b0;
    end else begin
      if (valid_instr_exec_i && (state_q == CAPTURE)) begin
        pc_q <= pc_i;
      end
      if (lane_mismatch) begin
        mismcnt_q <= sat_inc(mismcnt_q);
      end
      mismatch_q <= lane_mismatch && (state_q == CAPTURE);
      if (commit) begin
        ckpt_valid_q <= 1'b1;
      end
    end
  end

  assign win_hit = (bus.data_addr[31:8] == BaseAddr[31:8]) && (bus.data_addr[1:0] == 2'b00);
  assign idx     = bus.data_addr[7:2];

  // Reads see the registered shadow, so a same-cycle commit is not yet visible.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (!win_hit || bus.data_we) begin
      rd_err = 1'b1;
    end else if (!idx[5]) begin
      if (idx[4:0] != 5'd0) begin
        rd_data = shadow_q[idx[4:0]];
      end
    end else begin
      case (idx)
        IDX_PC:      rd_data = pc_q;
        IDX_STATUS:  rd_data = {29'b0, state_q == RECOVER, state_q == FROZEN, ckpt_valid_q};
        IDX_MISMCNT: rd_data = {{(32 - MISMCNT_W){1'b0}}, mismcnt_q};
        default:     rd_err  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= bus.data_req;
      if (bus.data_req) begin
        rdata_q <= rd_err ? 32'h0 : rd_data;
        err_q   <= rd_err;
      end
    end
  end

  assign unused_bus = ^{bus.data_be, bus.data_wdata};

  assign bus.data_gnt    = bus.data_req;
  assign bus.data_rvalid = rvalid_q;
  assign bus.data_rdata  = rdata_q;
  assign bus.data_err    = err_q;
  assign mismatch_o      = mismatch_q;
  assign ckpt_valid_o    = ckpt_valid_q;

endmodule

// File: tb/tb_ftm_ckpt_responder.sv
// tb/tb_ftm_ckpt_responder.sv - self-checking bench for ftm_ckpt_responder
module tb_ftm_ckpt_responder;

  localparam logic [31:0] BASE = 32'h0000_F000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic [31:0] offs;
    logic        we;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we_a, we_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic [31:0] pc;
  logic        valid_exec;
  logic        recovering;
  logic        mismatch, ckpt_valid;

  int n_total = 0;
  int n_pass  = 0;
  resp_t sb[$];
  vec_t  vecs[13];

  ftm_ckpt_responder_if bus ();

  ftm_ckpt_responder #(.BaseAddr(BASE)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .we_a_i             (we_a),
    .we_b_i             (we_b),
    .addr_a_i           (addr_a),
    .addr_b_i           (addr_b),
    .data_a_i           (data_a),
    .data_b_i           (data_b),
    .pc_i               (pc),
    .valid_instr_exec_i (valid_exec),
    .recovering_i       (recovering),
    .bus                (bus),
    .mismatch_o         (mismatch),
    .ckpt_valid_o       (ckpt_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_drive(input logic [31:0] addr, input logic we,
                           input logic [31:0] exp_rdata, input logic exp_err);
    resp_t r;
    bus.data_req   = 1'b1;
    bus.data_addr  = addr;
    bus.data_we    = we;
    bus.data_be    = 4'hF;
    bus.data_wdata = 32'hCAFE_0000;
    r.rdata = exp_rdata;
    r.err   = exp_err;
    sb.push_back(r);
  endtask

  task automatic bus_idle();
    bus.data_req = 1'b0;
    bus.data_we  = 1'b0;
  endtask

  task automatic read_one(input logic [31:0] offs, input logic [31:0] exp_rdata);
    bus_drive(BASE + offs, 1'b0, exp_rdata, 1'b0);
    tick();
    bus_idle();
    tick();
  endtask

  task automatic lane_set(input logic wa, input logic wb, input logic [4:0] aa,
                          input logic [4:0] ab, input logic [31:0] da, input logic [31:0] db);
    we_a = wa; we_b = wb; addr_a = aa; addr_b = ab; data_a = da; data_b = db;
  endtask

  task automatic lane_idle();
    lane_set(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
  endtask

  // Scoreboard: every response is popped in order and compared against what was queued at issue.
  always @(negedge clk) begin
    resp_t r;
    if (bus.data_req) begin
      check("gnt", {31'b0, bus.data_gnt}, 32'd1);
    end
    if (bus.data_rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        r = sb.pop_front();
        check("rdata", bus.data_rdata, r.rdata);
        check("err", {31'b0, bus.data_err}, {31'b0, r.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'h14,  1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{32'h80,  1'b0, 32'h0000_0080, 1'b0};
    vecs[2]  = '{32'h84,  1'b0, 32'h0000_0005, 1'b0};
    vecs[3]  = '{32'h88,  1'b0, 32'h0000_0000, 1'b0};
    vecs[4]  = '{32'h00,  1'b0, 32'h0000_0000, 1'b0};
    vecs[5]  = '{32'hA0,  1'b0, 32'h0000_0000, 1'b1};
    vecs[6]  = '{32'h10,  1'b1, 32'h0000_0000, 1'b1};
    vecs[7]  = '{32'h11,  1'b0, 32'h0000_0000, 1'b1};
    vecs[8]  = '{32'h04,  1'b0, 32'h1000_0001, 1'b0};
    vecs[9]  = '{32'h08,  1'b0, 32'h1000_0002, 1'b0};
    vecs[10] = '{32'h0C,  1'b0, 32'h1000_0003, 1'b0};
    vecs[11] = '{32'h10,  1'b0, 32'h1000_0004, 1'b0};
    vecs[12] = '{32'h100, 1'b0, 32'h0000_0000, 1'b1};

    rst_n = 1'b0;
    lane_idle();
    pc = 32'h0;
    valid_exec = 1'b0;
    recovering = 1'b0;
    bus.data_be = 4'h0;
    bus.data_addr = 32'h0;
    bus.data_wdata = 32'h0;
    bus_idle();
    repeat (2) tick();
    #2;
    check("reset_rvalid", {31'b0, bus.data_rvalid}, 32'd0);
    check("reset_rdata", bus.data_rdata, 32'd0);
    check("reset_err", {31'b0, bus.data_err}, 32'd0);
    check("reset_mismatch", {31'b0, mismatch}, 32'd0);
    check("reset_ckpt_valid", {31'b0, ckpt_valid}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 1; i <= 4; i++) begin
      lane_set(1'b1, 1'b1, 5'(i), 5'(i), 32'h1000_0000 + i, 32'h1000_0000 + i);
      tick();
    end
    lane_set(1'b1, 1'b1, 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    tick();
    lane_idle();
    #2;
    check("ckpt_valid_set", {31'b0, ckpt_valid}, 32'd1);

    pc = 32'h80; valid_exec = 1'b1;
    tick();
    pc = 32'h0; valid_exec = 1'b0;
    recovering = 1'b1;
    tick();
    pc = 32'h99; valid_exec = 1'b1;
    tick();
    valid_exec = 1'b0;

    for (int i = 0; i < 13; i++) begin
      bus_drive(BASE + vecs[i].offs, vecs[i].we, vecs[i].exp_rdata, vecs[i].exp_err);
      tick();
      #2;
      check($sformatf("b2b_rvalid_%0d", i), {31'b0, bus.data_rvalid}, 32'd1);
    end
    bus_idle();
    repeat (2) tick();

    recovering = 1'b0;
    tick();
    lane_set(1'b1, 1'b1, 5'd5, 5'd5, 32'h2, 32'h1);
    tick();
    lane_idle();
    #2;
    check("mismatch_pulse", {31'b0, mismatch}, 32'd1);
    tick();
    #2;
    check("mismatch_one_cycle", {31'b0, mismatch}, 32'd0);
    lane_set(1'b1, 1'b1, 5'd6, 5'd6, 32'h66, 32'h66);
    tick();
    lane_idle();
    read_one(32'h84, 32'h3);
    read_one(32'h14, 32'hDEAD_BEEF);
    read_one(32'h18, 32'h0);
    read_one(32'h88, 32'h1);

    lane_set(1'b1, 1'b0, 5'd9, 5'd0, 32'h1, 32'h0);
    tick();
    lane_idle();
    #2;
    check("frozen_no_pulse", {31'b0, mismatch}, 32'd0);
    read_one(32'h88, 32'h2);
    read_one(32'h24, 32'h0);

    recovering = 1'b1;
    tick();
    recovering = 1'b0;
    tick();
    read_one(32'h84, 32'h1);

    lane_set(1'b1, 1'b1, 5'd7, 5'd7, 32'hA5, 32'hA5);
    bus_drive(BASE + 32'h1C, 1'b0, 32'h0, 1'b0);
    tick();
    lane_idle();
    bus_drive(BASE + 32'h1C, 1'b0, 32'hA5, 1'b0);
    tick();
    bus_idle();
    repeat (2) tick();

    bus.data_req = 1'b1;
    bus.data_addr = BASE + 32'h14;
    bus.data_we = 1'b0;
    rst_n = 1'b0;
    tick();
    bus_idle();
    #2;
    check("reset_drops_rvalid", {31'b0, bus.data_rvalid}, 32'd0);
    check("reset_clears_valid", {31'b0, ckpt_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    #2;
    check("post_reset_no_rvalid", {31'b0, bus.data_rvalid}, 32'd0);
    for (int i = 0; i <= 34; i++) begin
      bus_drive(BASE + 32'(i * 4), 1'b0, 32'h0, 1'b0);
      tick();
    end
    bus_idle();
    repeat (3) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
